// File: rtl/button_conditioner.sv
// button_conditioner
//   Front end for the HH:MM:SS time-set buttons. Each raw active-low button
//   is synchronised, then debounced on a 1 kHz sample tick. While manual-set
//   mode is on, each button produces a one-clock increment strobe. The first
//   strobe comes on the press. Further strobes repeat after HOLD_TICKS ticks,
//   then every REPEAT_TICKS ticks while the button stays held.
//
// Ports
//   clock50MHz   in   system clock
//   resetn       in   asynchronous, active-low reset
//   push_button  in   [2:0] raw buttons, active-low (0=sec, 1=min, 2=hour)
//   man_switch   in   manual time-set enable, 1 = set mode
//   inc_pulse    out  [2:0] one-clock increment strobes
//   btn_level    out  [2:0] debounced state, 1 = pressed
//   tick_1k      out  one-clock sample tick, shared with neighbouring blocks
module button_conditioner #(
  parameter int TICK_DIV     = 49999,
  parameter int DB_LEN       = 8,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 200
) (
  input  logic       clock50MHz,
  input  logic       resetn,
  input  logic [2:0] push_button,
  input  logic       man_switch,
  output logic [2:0] inc_pulse,
  output logic [2:0] btn_level,
  output logic       tick_1k
);

  localparam int TW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  // Stage p0/p1: two-flop synchroniser. Idle level is released (1).
  logic [2:0] sync_p0;
  logic [2:0] sync_p1;
  logic [2:0] pressed;

  always_ff @(posedge clock50MHz or negedge resetn) begin
    if (!resetn) begin
      sync_p0 <= 3'b111;
      sync_p1 <= 3'b111;
    end else begin
      sync_p0 <= push_button;
      sync_p1 <= sync_p0;
    end
  end

  assign pressed = ~sync_p1;

  // Sample-tick divider: tick_1k is high for the cycle after the
  // terminal count, so the first tick follows TICK_DIV+1 clocks after reset.
  logic [TW-1:0] tick_cnt;

  always_ff @(posedge clock50MHz or negedge resetn) begin
    if (!resetn) begin
      tick_cnt <= '0;
      tick_1k  <= 1'b0;
    end else begin
      tick_1k <= (tick_cnt == TW'(TICK_DIV));
      if (tick_cnt == TW'(TICK_DIV)) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
    end
  end

  for (genvar b = 0; b < 3; b++) begin : g_btn
    // Debounce: only the last DB_LEN-1 samples are stored. The current
    // sample completes the window, so the level changes on the tick that
    // qualifies and is visible in the next cycle.
    logic [DB_LEN-2:0] db_hist;
    logic [DB_LEN-1:0] db_window;
    logic              level_q;

    assign db_window = {db_hist, pressed[b]};

    always_ff @(posedge clock50MHz or negedge resetn) begin
      if (!resetn) begin
        db_hist <= '0;
        level_q <= 1'b0;
      end else if (tick_1k) begin
        db_hist <= db_window[DB_LEN-2:0];
        if (&db_window) begin
          level_q <= 1'b1;
        end else if (~|db_window) begin
          level_q <= 1'b0;
        end
      end
    end

    assign btn_level[b] = level_q;

    // Press / hold / auto-repeat FSM.
    state_t     state;
    state_t     state_next;
    logic [9:0] hold_cnt;
    logic [9:0] hold_cnt_next;
    logic [9:0] hold_inc;
    logic       pulse_q;
    logic       pulse_next;

    // The counter saturates so it can never wrap past the compare value.
    assign hold_inc = (hold_cnt == 10'h3FF) ? hold_cnt : hold_cnt + 10'd1;

    always_ff @(posedge clock50MHz or negedge resetn) begin
      if (!resetn) begin
        state    <= IDLE;
        hold_cnt <= '0;
        pulse_q  <= 1'b0;
      end else begin
        state    <= state_next;
        hold_cnt <= hold_cnt_next;
        pulse_q  <= pulse_next;
      end
    end

    always_comb begin
      state_next    = state;
      hold_cnt_next = hold_cnt;
      pulse_next    = 1'b0;
      if (!man_switch || !level_q) begin
        // Leaving set mode or releasing the button always restarts cleanly.
        // A press that is still held when set mode returns counts as new.
        state_next    = IDLE;
        hold_cnt_next = '0;
      end else begin
        case (state)
          IDLE: begin
            state_next    = HOLD;
            hold_cnt_next = '0;
            pulse_next    = 1'b1;
          end
          HOLD: begin
            if (tick_1k) begin
              if (hold_inc >= 10'(HOLD_TICKS)) begin
                state_next    = REPEAT;
                hold_cnt_next = '0;
                pulse_next    = 1'b1;
              end else begin
                hold_cnt_next = hold_inc;
              end
            end
          end
          REPEAT: begin
            if (tick_1k) begin
              if (hold_inc >= 10'(REPEAT_TICKS)) begin
                hold_cnt_next = '0;
                pulse_next    = 1'b1;
              end else begin
                hold_cnt_next = hold_inc;
              end
            end
          end
          default: begin
            state_next    = IDLE;
            hold_cnt_next = '0;
          end
        endcase
      end
    end

    assign inc_pulse[b] = pulse_q;
  end

endmodule
